// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, repeated
// (repeat_n+1) times with gap_n idle cycles between frames.
module seq_pattern_tx #(
  parameter int PAT_W = 3,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap_n,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             frame_end,
  output logic             done
);

  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_reg;
  logic [PAT_W-1:0] shreg_reg;
  logic [PAT_W-1:0] pat_reg;
  logic [REP_W-1:0] frames_left_reg;
  logic [GAP_W-1:0] gap_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [BW-1:0]    bit_cnt_reg;

  // Outputs decode registered state only, so nothing flows from inputs to outputs.
  assign dout_valid = (state_reg == SEND);
  assign dout       = dout_valid & shreg_reg[PAT_W-1];
  assign busy       = (state_reg == SEND) || (state_reg == GAP);
  assign frame_end  = dout_valid && (bit_cnt_reg == '0);
  assign done       = (state_reg == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      shreg_reg       <= '0;
      pat_reg         <= '0;
      frames_left_reg <= '0;
      gap_reg         <= '0;
      gap_cnt_reg     <= '0;
      bit_cnt_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            shreg_reg       <= pattern;
            pat_reg         <= pattern;
            frames_left_reg <= repeat_n;
            gap_reg         <= gap_n;
            bit_cnt_reg     <= LAST_BIT;
            state_reg       <= SEND;
          end
        end
        SEND: begin
          if (bit_cnt_reg != '0) begin
            shreg_reg   <= {shreg_reg[PAT_W-2:0], 1'b0};
            bit_cnt_reg <= bit_cnt_reg - 1'b1;
          end else if (frames_left_reg == '0) begin
            shreg_reg <= '0;
            state_reg <= DONE;
          end else begin
            // Reload from the shadow copy; the live pattern input may have changed.
            frames_left_reg <= frames_left_reg - 1'b1;
            shreg_reg       <= pat_reg;
            bit_cnt_reg     <= LAST_BIT;
            if (gap_reg == '0) begin
              state_reg <= SEND;
            end else begin
              gap_cnt_reg <= gap_reg - 1'b1;
              state_reg   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt_reg == '0) begin
            state_reg <= SEND;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: table vectors, hand sequences and random stimulus,
// all checked against a per-cycle expected-output stream.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] pattern;
  logic [3:0] repeat_n;
  logic [3:0] gap_n;
  logic       dout;
  logic       dout_valid;
  logic       busy;
  logic       frame_end;
  logic       done;

  int errors;
  int checks;
  int cyc;

  seq_pattern_tx #(.PAT_W(3), .REP_W(4), .GAP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .repeat_n  (repeat_n),
    .gap_n     (gap_n),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .frame_end (frame_end),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs {dout, dout_valid, busy, frame_end, done}; head = current cycle.
  logic [4:0] exp_q[$];
  logic [4:0] exp_now;
  logic [4:0] got;

  // Whole run as a flat list of cycles: frames of PAT_W bits, gaps between, one done cycle.
  task automatic push_run(input logic [2:0] p, input logic [3:0] rn, input logic [3:0] gn);
    int nframes;
    nframes = int'(rn) + 1;
    $display("run: pattern=%b frames=%0d gap=%0d at cycle %0d", p, nframes, gn, cyc);
    for (int f = 0; f < nframes; f++) begin
      for (int b = 2; b >= 0; b--) begin
        exp_q.push_back({p[b], 1'b1, 1'b1, (b == 0), 1'b0});
      end
      if (f < nframes - 1) begin
        for (int g = 0; g < int'(gn); g++) exp_q.push_back(5'b00100);
      end
    end
    exp_q.push_back(5'b00001);
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%b expected=%b (dout,valid,busy,frame_end,done)",
               name, cyc, act, req);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic step(input logic r, input logic s, input logic [2:0] p,
                      input logic [3:0] rn, input logic [3:0] gn);
    rst = r; start = s; pattern = p; repeat_n = rn; gap_n = gn;
    @(posedge clk);
    cyc++;
    if (r) exp_q.delete();
    else if (exp_q.size() == 0) begin
      if (s) push_run(p, rn, gn);
    end else void'(exp_q.pop_front());
    #1;
    exp_now = (exp_q.size() != 0) ? exp_q[0] : 5'b00000;
    got = {dout, dout_valid, busy, frame_end, done};
    check("model", got, exp_now);
  endtask

  typedef struct {
    logic       r;
    logic       s;
    logic [2:0] p;
    logic [3:0] rn;
    logic [3:0] gn;
    logic [4:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic [2:0] p,
                              input logic [3:0] rn, input logic [3:0] gn, input logic [4:0] e);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.rn = rn; v.gn = gn; v.exp = e;
    return v;
  endfunction

  vec_t vecs[22];

  initial begin
    errors = 0; checks = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; pattern = '0; repeat_n = '0; gap_n = '0;

    // Reset held 3 cycles with start=1, then single frame 101 accepted right after.
    vecs[0]  = mk(1, 1, 3'b101, 0, 0, 5'b00000);
    vecs[1]  = mk(1, 1, 3'b101, 0, 0, 5'b00000);
    vecs[2]  = mk(1, 1, 3'b101, 0, 0, 5'b00000);
    vecs[3]  = mk(0, 1, 3'b101, 0, 0, 5'b11100);
    vecs[4]  = mk(0, 0, 3'b000, 0, 0, 5'b01100);
    vecs[5]  = mk(0, 0, 3'b000, 0, 0, 5'b11110);
    vecs[6]  = mk(0, 0, 3'b000, 0, 0, 5'b00001);
    vecs[7]  = mk(0, 0, 3'b000, 0, 0, 5'b00000);
    // Gapped: 110, two frames, gap 2.
    vecs[8]  = mk(0, 1, 3'b110, 1, 2, 5'b11100);
    vecs[9]  = mk(0, 0, 3'b000, 0, 0, 5'b11100);
    vecs[10] = mk(0, 0, 3'b000, 0, 0, 5'b01110);
    vecs[11] = mk(0, 0, 3'b000, 0, 0, 5'b00100);
    vecs[12] = mk(0, 0, 3'b000, 0, 0, 5'b00100);
    vecs[13] = mk(0, 0, 3'b000, 0, 0, 5'b11100);
    vecs[14] = mk(0, 0, 3'b000, 0, 0, 5'b11100);
    vecs[15] = mk(0, 0, 3'b000, 0, 0, 5'b01110);
    vecs[16] = mk(0, 0, 3'b000, 0, 0, 5'b00001);
    vecs[17] = mk(0, 0, 3'b000, 0, 0, 5'b00000);
    // Start ignored during a run: 011 requested mid-frame must not appear.
    vecs[18] = mk(0, 1, 3'b010, 0, 0, 5'b00100 | 5'b00000);
    vecs[19] = mk(0, 1, 3'b011, 0, 0, 5'b11100);
    vecs[20] = mk(0, 1, 3'b011, 0, 0, 5'b01110);
    vecs[21] = mk(0, 0, 3'b011, 0, 0, 5'b00001);
    // vecs[18]: pattern 010 accepted -> first bit 0, valid, busy.
    vecs[18].exp = 5'b01100;

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].rn, vecs[i].gn);
      check($sformatf("vec%0d", i), got, vecs[i].exp);
    end
    step(0, 0, 3'b000, 0, 0);
    check("vec_idle_after", got, 5'b00000);

    // Back-to-back: 101 x3, gap 0 -> continuous valid, done after 9 bits.
    step(0, 1, 3'b101, 2, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 3'b000, 0, 0);
    check("b2b_idle", got, 5'b00000);

    // Start held high, pattern flips to 011 mid-run; second run sends 011.
    step(0, 1, 3'b101, 0, 0);
    step(0, 1, 3'b101, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'b011, 0, 0);
    check("iso_idle_dead", got, 5'b00000);
    step(0, 1, 3'b011, 0, 0);
    check("iso_second_first_bit", got, 5'b01100);
    step(0, 0, 3'b000, 0, 0);
    check("iso_second_bit1", got, 5'b11100);
    for (int i = 0; i < 4; i++) step(0, 0, 3'b000, 0, 0);

    // Reset mid-frame: no done pulse, fresh run afterwards.
    step(0, 1, 3'b101, 3, 0);
    step(0, 0, 3'b000, 0, 0);
    step(1, 0, 3'b000, 0, 0);
    check("rst_mid_cleared", got, 5'b00000);
    step(0, 0, 3'b000, 0, 0);
    step(0, 1, 3'b110, 0, 0);
    check("rst_fresh_start", got, 5'b11100);
    for (int i = 0; i < 5; i++) step(0, 0, 3'b000, 0, 0);

    // Counter limits: 16 frames, 15 gap cycles each.
    step(0, 1, 3'b100, 4'hf, 4'hf);
    for (int i = 0; i < 16 * 3 + 15 * 15 + 2; i++) step(0, 0, 3'b000, 0, 0);
    check("limits_idle", got, 5'b00000);

    // Random traffic with live inputs changing every cycle.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
           3'($urandom), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
